// File: rtl/l1_memory_arbiter_pkg.sv
// ============================================================================
// Module      : l1_memory_arbiter_pkg
// Description : Definitions shared by the L1 instruction cache, the L1 data
//               cache and the memory arbiter. It holds the bus transfer
//               encodings, the arbiter state encoding and the owner
//               identifiers.
// Contents    : TRANS_IDLE / TRANS_NONSEQ  transfer-type encodings
//               arb_state_e                arbiter FSM state encoding
//               OWNER_I / OWNER_D          requester identifiers
//               trans_active()             "requester wants the bus" decode
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package l1_memory_arbiter_pkg;

  // Bus transfer encodings driven by both caches.
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_GRANT_I = 2'b01,
    ARB_GRANT_D = 2'b10
  } arb_state_e;

  // Requester identity. This is a single bit so the other requester is ~owner.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // A requester is active only for a NONSEQ transfer. Every other encoding,
  // including the reserved ones, counts as idle.
  function automatic logic trans_active(input logic [1:0] trans);
    return (trans == TRANS_NONSEQ);
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1_memory_arbiter.sv
// ============================================================================
// Module      : l1_memory_arbiter
// Description : Two-way arbiter that places the L1 instruction cache and the
//               L1 data cache onto one memory port. A winner keeps the port
//               for a whole burst: LINE_BEATS beats for the icache, and either
//               LINE_BEATS beats or 1 beat for the dcache. When both caches
//               request together, the winner is chosen round-robin. At the end
//               of a burst the port passes directly to a waiting requester,
//               with no idle cycle in between.
// Ports       : clk             clock; all state changes on the rising edge
//               rst             asynchronous reset, active low
//               i_req_addr/i_write/i_trans          icache request
//               d_req_addr/d_write/d_wdata/d_trans/d_burst
//                                                   dcache request
//               mem_addr/mem_write/mem_wdata/mem_trans
//                                                   memory request (owner mux)
//               mem_data_valid/mem_rdata            memory beat response
//               i_data_valid/d_data_valid           beat routed to the owner
//               rdata           mem_rdata broadcast to both caches
//               i_grant/d_grant registered ownership flags
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module l1_memory_arbiter
  import l1_memory_arbiter_pkg::*;
#(
  parameter int LINE_BEATS = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  // icache request
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_write,
  input  logic [1:0]        i_trans,
  // dcache request
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_wdata,
  input  logic [1:0]        d_trans,
  input  logic              d_burst,
  // memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic [1:0]        mem_trans,
  input  logic              mem_data_valid,
  input  logic [ADDR_W-1:0] mem_rdata,
  // responses back to the caches
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [ADDR_W-1:0] rdata,
  output logic              i_grant,
  output logic              d_grant
);

  // The beat counter holds LINE_BEATS-1 down to 0. The width is kept at
  // least 1 so that a one-beat line still elaborates.
  localparam int              CNT_W      = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(LINE_BEATS - 1);

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------

  // Round-robin tie break: the requester that did not own the port last wins.
  function automatic logic rr_pick(input logic last);
    return (last == OWNER_D) ? OWNER_I : OWNER_D;
  endfunction

  // Beats remaining after the first one. The icache always moves a full line.
  // For the dcache, d_burst is sampled when the grant starts.
  function automatic logic [CNT_W-1:0] load_count(input logic owner,
                                                  input logic burst);
    if (owner == OWNER_I || burst) begin
      return FULL_COUNT;
    end
    return '0;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e       state;
  logic [CNT_W-1:0] beats_left;
  logic             last_owner;

  // --------------------------------------------------------------------------
  // Transition decisions
  // --------------------------------------------------------------------------
  logic i_act;
  logic d_act;
  logic cur_owner;
  logic own_act;
  logic other_act;
  logic start_grant;
  logic start_owner;
  logic go_idle;
  logic count_beat;

  assign i_act     = trans_active(i_trans);
  assign d_act     = trans_active(d_trans);
  assign cur_owner = (state == ARB_GRANT_D) ? OWNER_D : OWNER_I;
  assign own_act   = (cur_owner == OWNER_D) ? d_act : i_act;
  assign other_act = (cur_owner == OWNER_D) ? i_act : d_act;

  // start_grant covers three cases: a fresh grant from IDLE, a handoff to the
  // other requester, and a reload for the same owner. All three load the
  // counter and update last_owner in the same way.
  always_comb begin
    start_grant = 1'b0;
    start_owner = OWNER_I;
    go_idle     = 1'b0;
    count_beat  = 1'b0;
    case (state)
      ARB_IDLE: begin
        // A stray mem_data_valid in IDLE is ignored.
        if (i_act || d_act) begin
          start_grant = 1'b1;
          if (i_act && d_act) begin
            start_owner = rr_pick(last_owner);
          end else begin
            start_owner = d_act ? OWNER_D : OWNER_I;
          end
        end
      end
      ARB_GRANT_I, ARB_GRANT_D: begin
        // The owner's trans may drop between beats. The grant is held until
        // the final beat, and a request from the non-owner waits until then.
        if (mem_data_valid) begin
          if (beats_left == '0) begin
            if (other_act) begin
              // A waiting requester takes over without an idle cycle.
              start_grant = 1'b1;
              start_owner = ~cur_owner;
            end else if (own_act) begin
              // No one else is waiting, so the owner keeps the port for
              // another burst.
              start_grant = 1'b1;
              start_owner = cur_owner;
            end else begin
              go_idle = 1'b1;
            end
          end else begin
            count_beat = 1'b1;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM with registered grant outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      beats_left <= '0;
      last_owner <= OWNER_D;   // after reset, the icache wins the first tie
      i_grant    <= 1'b0;
      d_grant    <= 1'b0;
    end else if (start_grant) begin
      if (start_owner == OWNER_D) begin
        state <= ARB_GRANT_D;
      end else begin
        state <= ARB_GRANT_I;
      end
      i_grant    <= (start_owner == OWNER_I);
      d_grant    <= (start_owner == OWNER_D);
      last_owner <= start_owner;
      beats_left <= load_count(start_owner, d_burst);
    end else if (go_idle) begin
      state      <= ARB_IDLE;
      beats_left <= '0;
      i_grant    <= 1'b0;
      d_grant    <= 1'b0;
    end else if (count_beat) begin
      beats_left <= beats_left - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Memory-side mux and response routing
  // --------------------------------------------------------------------------
  // These signals are steered by the registered grant flags. A reset clears
  // the flags at once, so the memory port and both valids drop immediately.
  always_comb begin
    mem_addr  = '0;
    mem_write = 1'b0;
    mem_wdata = '0;
    mem_trans = TRANS_IDLE;
    if (i_grant) begin
      mem_addr  = i_req_addr;
      mem_write = i_write;
      mem_trans = i_trans;
    end else if (d_grant) begin
      mem_addr  = d_req_addr;
      mem_write = d_write;
      mem_wdata = d_wdata;
      mem_trans = d_trans;
    end
  end

  assign i_data_valid = i_grant & mem_data_valid;
  assign d_data_valid = d_grant & mem_data_valid;
  assign rdata        = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_l1_memory_arbiter.sv
// ============================================================================
// Module      : tb_l1_memory_arbiter
// Description : Self-checking bench for l1_memory_arbiter. A transaction-level
//               reference model tracks the owner, the beats still owed in the
//               current burst, and the last grant winner. Directed scenarios
//               and a random run both compare every DUT output against it.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_l1_memory_arbiter;
  import l1_memory_arbiter_pkg::*;

  localparam int LB = 16;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_write = 1'b0;
  logic [1:0]    i_trans = 2'b00;
  logic [AW-1:0] d_req_addr = '0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_wdata = '0;
  logic [1:0]    d_trans = 2'b00;
  logic          d_burst = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_write;
  logic [AW-1:0] mem_wdata;
  logic [1:0]    mem_trans;
  logic          mem_data_valid = 1'b0;
  logic [AW-1:0] mem_rdata = '0;
  logic          i_data_valid;
  logic          d_data_valid;
  logic [AW-1:0] rdata;
  logic          i_grant;
  logic          d_grant;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  l1_memory_arbiter #(.LINE_BEATS(LB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req_addr(i_req_addr), .i_write(i_write), .i_trans(i_trans),
    .d_req_addr(d_req_addr), .d_write(d_write), .d_wdata(d_wdata),
    .d_trans(d_trans), .d_burst(d_burst),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_trans(mem_trans), .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid), .rdata(rdata),
    .i_grant(i_grant), .d_grant(d_grant)
  );

  // --------------------------------------------------------------------------
  // Reference model: owner 0=none 1=I 2=D, left = beats still owed in the burst
  // --------------------------------------------------------------------------
  typedef struct packed {
    int owner;
    int left;
    int last;
  } model_t;

  model_t m = '{owner: 0, left: 0, last: 2};

  function automatic int burst_len(input int who);
    if (who == 1) return LB;
    return d_burst ? LB : 1;
  endfunction

  function automatic model_t model_step(input model_t s);
    model_t n;
    bit ia, da, oa, sa;
    int other;
    n  = s;
    ia = (i_trans == 2'b10);
    da = (d_trans == 2'b10);
    if (s.owner == 0) begin
      if (ia && da)  n.owner = (s.last == 1) ? 2 : 1;
      else if (ia)   n.owner = 1;
      else if (da)   n.owner = 2;
      if (n.owner != 0) begin
        n.last = n.owner;
        n.left = burst_len(n.owner);
      end
    end else if (mem_data_valid) begin
      n.left = s.left - 1;
      if (n.left == 0) begin
        other = 3 - s.owner;
        oa = (other == 1) ? ia : da;
        sa = (s.owner == 1) ? ia : da;
        if (oa) begin
          n.owner = other;
          n.last  = other;
          n.left  = burst_len(other);
        end else if (sa) begin
          n.left = burst_len(s.owner);
        end else begin
          n.owner = 0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '{owner: 0, left: 0, last: 2};
    else      m <= model_step(m);
  end

  typedef logic [102:0] vec_t;

  function automatic vec_t exp_vec();
    logic ig, dg, wr, iv, dv;
    logic [1:0] tr;
    logic [AW-1:0] a, wd;
    ig = (m.owner == 1);
    dg = (m.owner == 2);
    a  = ig ? i_req_addr : (dg ? d_req_addr : '0);
    wr = ig ? i_write : (dg ? d_write : 1'b0);
    wd = dg ? d_wdata : '0;
    tr = ig ? i_trans : (dg ? d_trans : 2'b00);
    iv = ig && mem_data_valid;
    dv = dg && mem_data_valid;
    return {ig, dg, tr, wr, a, wd, iv, dv, mem_rdata};
  endfunction

  function automatic vec_t obs_vec();
    return {i_grant, d_grant, mem_trans, mem_write, mem_addr, mem_wdata,
            i_data_valid, d_data_valid, rdata};
  endfunction

  // Stimulus helpers (drive only, no checking)
  task automatic idle_inputs();
    i_trans = 2'b00; d_trans = 2'b00; i_write = 1'b0; d_write = 1'b0;
    d_burst = 1'b0;  mem_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    i_trans = 2'b10; d_trans = 2'b10; mem_data_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++;
      if ({i_grant, d_grant, mem_trans, mem_write, mem_addr, mem_wdata,
           i_data_valid, d_data_valid} !== '0) begin
        bad++;
        $display("FAIL reset_outputs cyc=%0d actual=%h required=0", c,
                 {i_grant, d_grant, mem_trans, mem_write, mem_addr, mem_wdata,
                  i_data_valid, d_data_valid});
      end
      total++;
      if (rdata !== 32'h1234_5678) begin
        bad++;
        $display("FAIL reset_rdata actual=%h required=12345678", rdata);
      end
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_i_only();
    int nv;
    nv = 0;
    do_reset();
    @(negedge clk);
    i_trans = 2'b10; i_req_addr = 32'h0000_4040;
    #1;
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL i_only_req actual=%h required=%h", obs_vec(), exp_vec());
    end
    for (int b = 1; b <= LB; b++) begin
      @(negedge clk);
      if (b > 8) i_trans = 2'b00;
      mem_data_valid = 1'b1; mem_rdata = $urandom;
      #1;
      if (i_data_valid === 1'b1) nv++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL i_only_beat%0d actual=%h required=%h", b, obs_vec(), exp_vec());
      end
      if (b == 1) begin
        total++;
        if ({i_grant, d_grant, mem_addr, mem_trans} !== {1'b1, 1'b0, 32'h0000_4040, 2'b10}) begin
          bad++;
          $display("FAIL i_only_first_grant actual=%h required=%h",
                   {i_grant, d_grant, mem_addr, mem_trans}, {1'b1, 1'b0, 32'h0000_4040, 2'b10});
        end
      end
    end
    @(negedge clk);
    mem_data_valid = 1'b0;
    #1;
    total++;
    if ({i_grant, d_grant} !== 2'b00 || nv != LB) begin
      bad++; $display("FAIL i_only_end grants=%b beats=%0d required grants=00 beats=%0d",
                      {i_grant, d_grant}, nv, LB);
    end
  endtask

  task automatic test_tie();
    int nv;
    nv = 0;
    do_reset();
    @(negedge clk);
    i_trans = 2'b10; d_trans = 2'b10; d_burst = 1'b1;
    i_req_addr = 32'h0000_1000; d_req_addr = 32'h0000_2000;
    #1;
    for (int b = 1; b <= LB; b++) begin
      @(negedge clk);
      if (b > 1) i_trans = 2'b00;
      mem_data_valid = 1'b1; mem_rdata = $urandom;
      #1;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL tie_i_beat%0d actual=%h required=%h", b, obs_vec(), exp_vec());
      end
      if (b == 1) begin
        total++;
        if ({i_grant, d_grant} !== 2'b10) begin
          bad++; $display("FAIL tie_first_winner actual=%b required=10", {i_grant, d_grant});
        end
      end
    end
    @(negedge clk);
    mem_data_valid = 1'b0; d_trans = 2'b00;
    #1;
    total++;
    if ({i_grant, d_grant} !== 2'b01) begin
      bad++; $display("FAIL tie_handoff actual=%b required=01", {i_grant, d_grant});
    end
    for (int b = 1; b <= LB; b++) begin
      @(negedge clk);
      mem_data_valid = 1'b1; mem_rdata = $urandom;
      #1;
      if (d_data_valid === 1'b1) nv++;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL tie_d_beat%0d actual=%h required=%h", b, obs_vec(), exp_vec());
      end
    end
    @(negedge clk);
    mem_data_valid = 1'b0;
    #1;
    total++;
    if ({i_grant, d_grant} !== 2'b00 || nv != LB) begin
      bad++; $display("FAIL tie_d_end grants=%b beats=%0d required grants=00 beats=%0d",
                      {i_grant, d_grant}, nv, LB);
    end
  endtask

  task automatic test_d_single();
    do_reset();
    @(negedge clk);
    d_trans = 2'b10; d_burst = 1'b0; d_write = 1'b1;
    d_wdata = 32'hDEAD_BEEF; d_req_addr = 32'h0000_0ABC;
    @(negedge clk);
    #1;
    total++;
    if ({d_grant, mem_write, mem_wdata, mem_addr} !== {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0ABC}) begin
      bad++; $display("FAIL d_single_drive actual=%h required=%h",
                      {d_grant, mem_write, mem_wdata, mem_addr},
                      {1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0ABC});
    end
    @(negedge clk);
    mem_data_valid = 1'b1; d_trans = 2'b00; d_burst = 1'b1;
    #1;
    total++;
    if (obs_vec() !== exp_vec() || d_data_valid !== 1'b1) begin
      bad++; $display("FAIL d_single_beat actual=%h required=%h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    mem_data_valid = 1'b0; d_write = 1'b0;
    #1;
    total++;
    if ({i_grant, d_grant} !== 2'b00) begin
      bad++; $display("FAIL d_single_release actual=%b required=00", {i_grant, d_grant});
    end
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk);
    i_trans = 2'b10; i_req_addr = 32'h0000_8000; d_burst = 1'b0;
    for (int b = 1; b <= LB; b++) begin
      @(negedge clk);
      if (b == 5) begin d_trans = 2'b10; d_req_addr = 32'h0000_9000; end
      mem_data_valid = 1'b1; mem_rdata = $urandom;
      #1;
      total++;
      if (obs_vec() !== exp_vec() || d_data_valid !== 1'b0 || d_grant !== 1'b0) begin
        bad++; $display("FAIL contention_beat%0d actual=%h required=%h", b, obs_vec(), exp_vec());
      end
    end
    @(negedge clk);
    mem_data_valid = 1'b0;
    #1;
    total++;
    if ({i_grant, d_grant} !== 2'b01) begin
      bad++; $display("FAIL contention_handoff actual=%b required=01", {i_grant, d_grant});
    end
    // Let everything drain against the model.
    i_trans = 2'b00; d_trans = 2'b00;
    for (int c = 0; c < 2 * LB + 4; c++) begin
      @(negedge clk);
      mem_data_valid = 1'b1; mem_rdata = $urandom;
      #1;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL contention_drain%0d actual=%h required=%h", c, obs_vec(), exp_vec());
      end
    end
    mem_data_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    i_trans = 2'b10; i_req_addr = 32'h0000_4040;
    for (int b = 1; b <= 8; b++) begin
      @(negedge clk);
      mem_data_valid = 1'b1;
      #1;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_mid_beat%0d actual=%h required=%h", b, obs_vec(), exp_vec());
      end
    end
    #1;
    rst = 1'b0; i_trans = 2'b00;
    #1;
    total++;
    if ({i_grant, d_grant, mem_trans, mem_write, mem_addr, mem_wdata,
         i_data_valid, d_data_valid} !== '0) begin
      bad++; $display("FAIL reset_mid_immediate actual=%h required=0",
                      {i_grant, d_grant, mem_trans, mem_write, mem_addr, mem_wdata,
                       i_data_valid, d_data_valid});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_data_valid = 1'b1;
      #1;
      total++;
      if (i_data_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_mid_after%0d i_data_valid=%b required=0", c, i_data_valid);
      end
    end
    mem_data_valid = 1'b0;
  endtask

  task automatic test_stray();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      mem_data_valid = 1'b1; mem_rdata = $urandom;
      #1;
      total++;
      if ({i_grant, d_grant, i_data_valid, d_data_valid} !== 4'b0000 ||
          obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL stray_valid%0d actual=%b required=0000", c,
                        {i_grant, d_grant, i_data_valid, d_data_valid});
      end
    end
    mem_data_valid = 1'b0;
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst == 1'b0) rst = 1'b1;
      r = $urandom_range(0, 9);
      i_trans = (r < 4) ? 2'b10 : ((r < 8) ? 2'b00 : 2'($urandom_range(0, 3)));
      r = $urandom_range(0, 9);
      d_trans = (r < 4) ? 2'b10 : ((r < 8) ? 2'b00 : 2'($urandom_range(0, 3)));
      i_req_addr = $urandom; d_req_addr = $urandom; d_wdata = $urandom;
      i_write = ($urandom_range(0, 7) == 0);
      d_write = $urandom_range(0, 1);
      d_burst = ($urandom_range(0, 3) == 0);
      mem_data_valid = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      #1;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_cyc%0d actual=%h required=%h", c, obs_vec(), exp_vec());
      end
      if ($urandom_range(0, 399) == 0) begin
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (obs_vec() !== exp_vec() || {i_grant, d_grant} !== 2'b00) begin
          bad++; $display("FAIL random_reset_cyc%0d actual=%h required=%h", c, obs_vec(), exp_vec());
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_tie();
    test_d_single();
    test_contention();
    test_reset_mid();
    test_stray();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/l1_memory_arbiter.md
L1_MEMORY_ARBITER -- requirements
Module: l1_memory_arbiter

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 16, words per cache-line burst.
REQ-002 SHALL have parameter ADDR_W, default 32, address/data width.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: i_req_addr  in  32  icache request address; i_write  in  1  icache write (always 0 from icache); i_trans  in  2  icache transfer (2'b10 active, 2'b00 idle).
REQ-006 SHALL have ports: d_req_addr  in  32; d_write  in  1; d_wdata  in  32; d_trans  in  2; d_burst  in  1  1=line burst, 0=single word; sampled at grant.
REQ-007 SHALL have ports: mem_addr  out  32; mem_write  out  1; mem_wdata  out  32; mem_trans  out  2; mem_data_valid  in  1  beat complete; mem_rdata  in  32.
REQ-008 SHALL have ports: i_data_valid  out  1; d_data_valid  out  1; rdata  out  32  (mem_rdata broadcast); i_grant  out  1; d_grant  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT_I, GRANT_D; i_grant/d_grant are the registered state decode.
REQ-010 In IDLE, requester active means trans==2'b10; single requester wins next cycle; both active -> round-robin by last_owner (non-last owner wins).
REQ-011 On grant SHALL load beats_left = LINE_BEATS-1 for I, or for D: LINE_BEATS-1 if d_burst else 0.
REQ-012 While granted, mem_addr/mem_write/mem_wdata/mem_trans SHALL combinationally follow owner inputs (I: mem_wdata=0); in IDLE all are 0.
REQ-013 Grant SHALL be held for the whole burst even when the owner drops trans between beats; non-owner trans ignored.
REQ-014 mem_data_valid SHALL route only to owner's *_data_valid, same cycle; non-owner valid 0; in IDLE both 0.
REQ-015 Each routed beat decrements beats_left (4-bit for default; width clog2(LINE_BEATS)); beat with beats_left==0 is final.
REQ-016 On final beat: other requester active -> direct handoff to its GRANT state next cycle (no bubble); else owner active -> remain granted and reload count only if other idle; else IDLE.
REQ-017 last_owner SHALL update at every grant start.
REQ-018 mem_data_valid in IDLE SHALL be ignored, no state change.
REQ-019 Latency: request to mem_trans active = 1 cycle from IDLE.

Reset
REQ-020 On rst low, asynchronously: state IDLE, beats_left 0, last_owner = D (icache wins first tie), i_grant=d_grant=0, hence all mem_* outputs and *_data_valid 0.
REQ-021 Reset mid-burst SHALL abandon the burst; no beat delivered to either requester after reset asserts.

Structure
REQ-022 Transfer encodings TRANS_IDLE=2'b00, TRANS_NONSEQ=2'b10 and state encoding SHALL reside in a shared package used by caches and arbiter.
REQ-023 Single module, no sub-modules; the round-robin pick is an in-module function.

Verification
REQ-024 I-only: i_trans=2'b10, addr 0x0000_4040, 16 valid beats -> i_grant cycle after request, mem_addr=0x4040 path, 16 i_data_valid, IDLE after beat 16.
REQ-025 Tie after reset: both request same cycle -> GRANT_I first; D then granted directly on I's final beat, zero idle cycles.
REQ-026 D single: d_burst=0, d_write=1, d_wdata=0xDEADBEEF -> mem_write=1, mem_wdata=0xDEADBEEF, grant released after 1 beat.
REQ-027 Contention: D requests during I burst beat 5 -> d_data_valid stays 0, d_grant only after I beat 16.
REQ-028 Reset at I beat 8 -> all outputs 0 immediately; subsequent mem_data_valid pulses produce no i_data_valid.
REQ-029 Stray mem_data_valid in IDLE -> no grant, no *_data_valid.
